// File: rtl/cs_subtractor_pipe_if.sv
// cs_subtractor_pipe_if: operand and result valid/ready bus of the carry-select subtractor
interface cs_subtractor_pipe_if #(
  parameter int WIDTH = 32
);
  logic in_valid, in_ready, bin, out_valid, out_ready, bout, of;
  logic [WIDTH-1:0] A, B, diff;
  modport master (output in_valid, A, B, bin, out_ready, input in_ready, out_valid, diff, bout, of);
  modport slave (input in_valid, A, B, bin, out_ready, output in_ready, out_valid, diff, bout, of);
endinterface

// File: rtl/cs_subtractor_pipe.sv
// cs_subtractor_pipe: two-stage carry-select subtractor, diff = A - B - bin, behind valid/ready
module cs_subtractor_pipe #(
  parameter int WIDTH = 32
) (
  input logic clk,
  input logic rst_n,
  cs_subtractor_pipe_if.slave bus
);
  localparam int HALF = WIDTH / 2;
  logic s1_valid_q, s1_valid_d, s1_c_q, s1_c_d, s1_c0_q, s1_c0_d, s1_c1_q, s1_c1_d;
  logic s1_a_msb_q, s1_a_msb_d, s1_b_msb_q, s1_b_msb_d;
  logic [HALF-1:0] s1_lo_q, s1_lo_d, s1_hi0_q, s1_hi0_d, s1_hi1_q, s1_hi1_d, hi_sel;
  logic out_valid_q, out_valid_d, bout_q, bout_d, of_q, of_d, c_sel, s1_adv, s2_adv;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [HALF:0] lo_sum, hi0_sum, hi1_sum;
  // high half resolved late: the registered low carry picks the speculative result
  for (genvar i = 0; i < HALF; i++) begin : g_sel
    assign hi_sel[i] = s1_c_q ? s1_hi1_q[i] : s1_hi0_q[i];
  end
  assign c_sel = s1_c_q ? s1_c1_q : s1_c0_q;
  always_comb begin
    s2_adv = !out_valid_q || bus.out_ready;
    s1_adv = !s1_valid_q || s2_adv;
    lo_sum = {1'b0, bus.A[HALF-1:0]} + {1'b0, ~bus.B[HALF-1:0]} + {{HALF{1'b0}}, ~bus.bin};
    hi0_sum = {1'b0, bus.A[WIDTH-1:HALF]} + {1'b0, ~bus.B[WIDTH-1:HALF]};
    hi1_sum = {1'b0, bus.A[WIDTH-1:HALF]} + {1'b0, ~bus.B[WIDTH-1:HALF]} + {{HALF{1'b0}}, 1'b1};
    {s1_c_d, s1_lo_d} = s1_adv ? lo_sum : {s1_c_q, s1_lo_q};
    {s1_c0_d, s1_hi0_d} = s1_adv ? hi0_sum : {s1_c0_q, s1_hi0_q};
    {s1_c1_d, s1_hi1_d} = s1_adv ? hi1_sum : {s1_c1_q, s1_hi1_q};
    s1_a_msb_d = s1_adv ? bus.A[WIDTH-1] : s1_a_msb_q;
    s1_b_msb_d = s1_adv ? bus.B[WIDTH-1] : s1_b_msb_q;
    s1_valid_d = s1_adv ? bus.in_valid : s1_valid_q;
    out_valid_d = s2_adv ? s1_valid_q : out_valid_q;
    diff_d = s2_adv ? {hi_sel, s1_lo_q} : diff_q;
    bout_d = s2_adv ? ~c_sel : bout_q;
    of_d = s2_adv ? (s1_a_msb_q != s1_b_msb_q) && (hi_sel[HALF-1] != s1_a_msb_q) : of_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_c_q <= 1'b0;
      s1_c0_q <= 1'b0;
      s1_c1_q <= 1'b0;
      s1_lo_q <= '0;
      s1_hi0_q <= '0;
      s1_hi1_q <= '0;
      s1_a_msb_q <= 1'b0;
      s1_b_msb_q <= 1'b0;
      out_valid_q <= 1'b0;
      diff_q <= '0;
      bout_q <= 1'b0;
      of_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_c_q <= s1_c_d;
      s1_c0_q <= s1_c0_d;
      s1_c1_q <= s1_c1_d;
      s1_lo_q <= s1_lo_d;
      s1_hi0_q <= s1_hi0_d;
      s1_hi1_q <= s1_hi1_d;
      s1_a_msb_q <= s1_a_msb_d;
      s1_b_msb_q <= s1_b_msb_d;
      out_valid_q <= out_valid_d;
      diff_q <= diff_d;
      bout_q <= bout_d;
      of_q <= of_d;
    end
  end
  assign bus.in_ready = s1_adv;
  assign bus.out_valid = out_valid_q;
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;
  assign bus.of = of_q;
endmodule
